// File: rtl/prefix_expr_pkg.sv
`default_nettype none
// prefix_expr_pkg: token fields, opcode/mode constants, FSM states and output-width helper (rev 1.0)
package prefix_expr_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [1:0] MODE_PRE  = 2'b00;
  localparam logic [1:0] MODE_POST = 2'b01;
  localparam logic [1:0] MODE_CONV = 2'b10;

  // Operator precedence lives in opcode bit 1 (* and / bind tighter)
  localparam int PREC_BIT = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PROC = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic int calc_out_w(input int ntok, input int tok_w, input int data_w);
    return (ntok * tok_w > data_w) ? ntok * tok_w : data_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/prefix_expr_alu.sv
`default_nettype none
// prefix_expr_alu: combinational signed +,-,*,/ with divide-by-zero detect (rev 1.0)
module prefix_expr_alu
  import prefix_expr_pkg::*;
#(
  parameter int DATA_W = 41
) (
  input  logic [1:0]               op,
  input  logic signed [DATA_W-1:0] lhs,
  input  logic signed [DATA_W-1:0] rhs,
  output logic signed [DATA_W-1:0] res,
  output logic                     div_by_zero
);

  always_comb begin
    res         = '0;
    div_by_zero = 1'b0;
    case (op)
      OP_ADD:  res = lhs + rhs;
      OP_SUB:  res = lhs - rhs;
      OP_MUL:  res = lhs * rhs;
      default: begin
        // Zero divisor yields 0 and flags; signed / already truncates toward zero
        if (rhs == '0) div_by_zero = 1'b1;
        else           res = lhs / rhs;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/prefix_expr_engine.sv
`default_nettype none
// prefix_expr_engine: prefix/postfix evaluator and infix->postfix converter over one NTOK-token packet (rev 1.0)
module prefix_expr_engine
  import prefix_expr_pkg::*;
#(
  parameter  int N_OPND = 10,
  parameter  int TOK_W  = 5,
  parameter  int DATA_W = 41,
  localparam int NTOK   = 2 * N_OPND - 1,
  localparam int OUT_W  = calc_out_w(NTOK, TOK_W, DATA_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [1:0]       mode,
  input  logic [TOK_W-1:0] in_data,
  output logic             out_valid,
  output logic [OUT_W-1:0] out,
  output logic             out_err
);

  localparam int CNT_W = $clog2(NTOK + 1);
  localparam int SP_W  = $clog2(N_OPND + 1);
  localparam int BUF_W = NTOK * TOK_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NTOK - 1);
  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(NTOK);
  localparam logic [SP_W-1:0]  SP_FULL  = SP_W'(N_OPND);
  localparam logic [SP_W-1:0]  SP_ONE   = SP_W'(1);
  localparam logic [SP_W-1:0]  SP_TWO   = SP_W'(2);

  state_t                   state, state_nxt;
  logic [1:0]               mode_lat;
  logic [CNT_W-1:0]         cnt;
  logic [TOK_W-1:0]         tok_buf [NTOK];
  logic signed [DATA_W-1:0] val_stk [N_OPND];
  logic [SP_W-1:0]          sp, sp_nxt;
  logic                     err_acc, err_final;
  logic [BUF_W-1:0]         emit_buf;

  logic                     scanning, last_scan, pop_cond, div_by_zero;
  logic                     wr_en, emit_en, adv, err_set;
  logic [SP_W-1:0]          wr_idx, top_idx, under_idx;
  logic [CNT_W-1:0]         tok_idx;
  logic [TOK_W-1:0]         cur_tok, emit_tok;
  logic signed [DATA_W-1:0] wr_val, top_val, under_val, opnd_val;
  logic signed [DATA_W-1:0] alu_lhs, alu_rhs, alu_res;

  // Convert mode reuses val_stk as the operator stack, holding zero-extended tokens
  assign scanning  = (cnt < CNT_END);
  assign last_scan = (cnt == CNT_LAST);
  assign tok_idx   = !scanning ? '0 : (mode_lat == MODE_PRE) ? CNT_LAST - cnt : cnt;
  assign cur_tok   = tok_buf[tok_idx];
  assign top_idx   = (sp == '0) ? '0 : sp - SP_ONE;
  assign under_idx = (sp < SP_TWO) ? '0 : sp - SP_TWO;
  assign top_val   = val_stk[top_idx];
  assign under_val = val_stk[under_idx];
  assign opnd_val  = DATA_W'(cur_tok[TOK_W-2:0]);
  assign alu_lhs   = (mode_lat == MODE_PRE) ? top_val : under_val;
  assign alu_rhs   = (mode_lat == MODE_PRE) ? under_val : top_val;
  assign pop_cond  = (sp != '0) && (top_val[PREC_BIT] >= cur_tok[PREC_BIT]);
  assign err_final = err_acc | ((mode_lat != MODE_CONV) && (sp != SP_ONE));

  prefix_expr_alu #(.DATA_W(DATA_W)) u_alu (
    .op          (cur_tok[1:0]),
    .lhs         (alu_lhs),
    .rhs         (alu_rhs),
    .res         (alu_res),
    .div_by_zero (div_by_zero)
  );

  always_comb begin
    state_nxt = state;
    sp_nxt    = sp;
    wr_en     = 1'b0;
    wr_idx    = '0;
    wr_val    = '0;
    emit_en   = 1'b0;
    emit_tok  = '0;
    adv       = 1'b0;
    err_set   = 1'b0;
    case (state)
      ST_IDLE: if (in_valid) state_nxt = ST_LOAD;
      ST_LOAD: begin
        if (!in_valid)              state_nxt = ST_IDLE;
        else if (cnt == CNT_LAST)   state_nxt = ST_PROC;
      end
      ST_PROC: begin
        if (mode_lat == MODE_CONV) begin
          if (!scanning) begin
            if (sp != '0) begin
              emit_en  = 1'b1;
              emit_tok = top_val[TOK_W-1:0];
              sp_nxt   = sp - SP_ONE;
            end
            if (sp <= SP_ONE) state_nxt = ST_DONE;
          end else if (!cur_tok[TOK_W-1]) begin
            emit_en  = 1'b1;
            emit_tok = cur_tok;
            adv      = 1'b1;
            if (last_scan && sp == '0) state_nxt = ST_DONE;
          end else if (pop_cond) begin
            // Token is held until the stack top no longer outranks it
            emit_en  = 1'b1;
            emit_tok = top_val[TOK_W-1:0];
            sp_nxt   = sp - SP_ONE;
          end else if (sp == SP_FULL) begin
            err_set = 1'b1;
            adv     = 1'b1;
          end else begin
            wr_en  = 1'b1;
            wr_idx = sp;
            wr_val = DATA_W'(cur_tok);
            sp_nxt = sp + SP_ONE;
            adv    = 1'b1;
          end
        end else begin
          adv = 1'b1;
          if (last_scan) state_nxt = ST_DONE;
          if (!cur_tok[TOK_W-1]) begin
            if (sp == SP_FULL) begin
              err_set = 1'b1;
            end else begin
              wr_en  = 1'b1;
              wr_idx = sp;
              wr_val = opnd_val;
              sp_nxt = sp + SP_ONE;
            end
          end else if (sp < SP_TWO) begin
            err_set = 1'b1;
            wr_en   = 1'b1;
            sp_nxt  = SP_ONE;
          end else begin
            wr_en   = 1'b1;
            wr_idx  = sp - SP_TWO;
            wr_val  = alu_res;
            sp_nxt  = sp - SP_ONE;
            err_set = div_by_zero;
          end
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      mode_lat  <= MODE_PRE;
      cnt       <= '0;
      sp        <= '0;
      err_acc   <= 1'b0;
      emit_buf  <= '0;
      out_valid <= 1'b0;
      out       <= '0;
      out_err   <= 1'b0;
      for (int i = 0; i < NTOK; i++)   tok_buf[i] <= '0;
      for (int i = 0; i < N_OPND; i++) val_stk[i] <= '0;
    end else begin
      state     <= state_nxt;
      out_valid <= 1'b0;
      out       <= '0;
      out_err   <= 1'b0;
      case (state)
        ST_IDLE: if (in_valid) begin
          tok_buf[0] <= in_data;
          mode_lat   <= (mode == MODE_POST || mode == MODE_CONV) ? mode : MODE_PRE;
          cnt        <= CNT_W'(1);
          sp         <= '0;
          err_acc    <= 1'b0;
          emit_buf   <= '0;
        end
        ST_LOAD: if (in_valid) begin
          tok_buf[cnt] <= in_data;
          cnt          <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        end
        ST_PROC: begin
          sp <= sp_nxt;
          if (wr_en)   val_stk[wr_idx] <= wr_val;
          if (emit_en) emit_buf <= {emit_buf[BUF_W-TOK_W-1:0], emit_tok};
          if (adv)     cnt <= cnt + 1'b1;
          if (err_set) err_acc <= 1'b1;
        end
        ST_DONE: begin
          out_valid <= 1'b1;
          out_err   <= err_final;
          if (mode_lat == MODE_CONV) out <= OUT_W'(emit_buf);
          else if (!err_final)       out <= OUT_W'(val_stk[0]);
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
